// File: rtl/comparator_if.sv
// comparator_if: operand/command/result bundle for the bit-serial comparator
//   a, b       : operands, WIDTH bits, driven by the controller
//   load, op   : start-comparison and publish-result commands
//   L, E, G    : one-hot result flags (a<b, a==b, a>b)
interface comparator_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic load;
  logic op;
  logic L;
  logic E;
  logic G;
  modport master (output a, b, load, op, input L, E, G);
  modport slave (input a, b, load, op, output L, E, G);
endinterface

// File: rtl/comparator.sv
// comparator: bit-serial unsigned magnitude comparator, one bit per clock, LSB first
//   clk : rising-edge clock
//   res : asynchronous active-low reset
//   bus : comparator_if slave (a, b, load, op in; registered L/E/G out)
module comparator #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic res,
  comparator_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {EQ, LT, GT} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic busy, done;
  logic [2:0] leg_d;
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      sa <= '0;
      sb <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (bus.load) begin
      sa <= bus.a;
      sb <= bus.b;
      cnt <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  always_ff @(posedge clk or negedge res)
    if (!res) state <= EQ;
    else state <= state_d;
  // Each later (more significant) differing bit overrides the verdict so far.
  always_comb
    state_d = bus.load ? EQ :
              !busy ? state :
              (sa[0] & ~sb[0]) ? GT :
              (~sa[0] & sb[0]) ? LT : state;
  // Publish only once finished and not being reloaded; otherwise hold.
  always_comb
    leg_d = (bus.op && done && !bus.load) ? {state == LT, state == EQ, state == GT}
                                          : {bus.L, bus.E, bus.G};
  always_ff @(posedge clk or negedge res)
    if (!res) {bus.L, bus.E, bus.G} <= 3'b000;
    else {bus.L, bus.E, bus.G} <= leg_d;
endmodule

// File: tb/tb_comparator.sv
// tb_comparator: directed scoreboard bench for the bit-serial comparator
module tb_comparator;
  localparam int W = 32;
  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;
  comparator_if #(.WIDTH(W)) bus ();
  comparator #(.WIDTH(W)) dut (.clk(clk), .res(res), .bus(bus));
  logic [2:0] q[$];
  logic [2:0] last = 3'b000;
  int tests = 0;
  int failed = 0;
  function automatic logic [2:0] model(logic [W-1:0] a, logic [W-1:0] b);
    return (a < b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(string tag);
    logic [2:0] got;
    logic [2:0] exp;
    got = {bus.L, bus.E, bus.G};
    exp = q.pop_front();
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got LEG=%b expected LEG=%b", tag, got, exp);
    end
    last = exp;
  endtask
  task automatic op_step(string tag, logic [2:0] exp);
    bus.op = 1'b1;
    q.push_back(exp);
    tick();
    bus.op = 1'b0;
    check(tag);
  endtask
  task automatic load_step(logic [W-1:0] a, logic [W-1:0] b);
    bus.a = a;
    bus.b = b;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask
  task automatic run(string tag, logic [W-1:0] a, logic [W-1:0] b);
    load_step(a, b);
    repeat (34) tick();
    op_step(tag, model(a, b));
    op_step({tag, "_rep"}, model(a, b));
  endtask
  initial begin
    logic [W-1:0] ra, rb;
    bus.a = '0;
    bus.b = '0;
    bus.load = 1'b0;
    bus.op = 1'b0;
    tick();
    tick();
    q.push_back(3'b000);
    check("reset");
    res = 1'b1;
    tick();
    op_step("op_before_load", 3'b000);
    run("lt", 32'h44444444, 32'h44464444);
    run("eq", 32'h44444444, 32'h44444444);
    run("gt", 32'h44464444, 32'h44444444);
    run("msb_gt", 32'h80000000, 32'h7FFFFFFF);
    run("msb_lt", 32'h00000001, 32'h00000002);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i == 0) ? ra : $urandom;
      run($sformatf("rand%0d", i), ra, rb);
    end
    bus.a = 32'd1;
    bus.b = 32'd2;
    bus.load = 1'b1;
    bus.op = 1'b1;
    q.push_back(last);
    tick();
    bus.load = 1'b0;
    bus.op = 1'b0;
    check("op_with_load");
    repeat (9) tick();
    op_step("early_op", last);
    repeat (9) tick();
    load_step(32'd5, 32'd5);
    repeat (31) tick();
    op_step("op_at_done_edge", last);
    op_step("restart_eq", 3'b010);
    load_step(32'h80000000, 32'd1);
    repeat (10) tick();
    @(negedge clk);
    res = 1'b0;
    #1;
    q.push_back(3'b000);
    check("async_reset");
    @(negedge clk);
    res = 1'b1;
    repeat (40) tick();
    op_step("op_after_reset", 3'b000);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
